// File: rtl/matrix_loader.sv
// matrix_loader: packs a stream of signed elements row-major into a flat
// 5x5 matrix bus, zeroing unused slots, with a valid/ack hold at the end.
module matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int N_MAX  = 25
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                size_in,
    input  logic [ELEM_W-1:0]         data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic [N_MAX*ELEM_W-1:0]   matrix_A,
    output logic [1:0]                matrix_size,
    output logic                      matrix_valid,
    input  logic                      ack,
    output logic                      busy,
    output logic [$clog2(N_MAX+1)-1:0] elem_count
);

    localparam int CNT_W = $clog2(N_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         size_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   last_idx;
    logic               load_start;
    logic               xfer;
    logic               last_xfer;

    // Index of the final element for the latched size code (N-1).
    always_comb begin
        last_idx = CNT_W'(24);
        case (size_reg)
            2'b00:   last_idx = CNT_W'(3);
            2'b01:   last_idx = CNT_W'(8);
            2'b10:   last_idx = CNT_W'(15);
            default: last_idx = CNT_W'(24);
        endcase
    end

    // start only matters in IDLE; elements only move while loading.
    assign load_start = (state_reg == S_IDLE) && start;
    assign xfer       = (state_reg == S_LOAD) && data_valid;
    assign last_xfer  = xfer && (count_reg == last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; ack wins over a simultaneous start in DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)     state_next = S_LOAD;
            S_LOAD:  if (last_xfer) state_next = S_DONE;
            S_DONE:  if (ack)       state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only, so no input-to-output path.
    always_comb begin
        data_ready   = (state_reg == S_LOAD);
        matrix_valid = (state_reg == S_DONE);
        busy         = (state_reg != S_IDLE);
    end

    // Size code and element counter: set up on start, counted per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_reg  <= 2'b00;
            count_reg <= '0;
        end else if (load_start) begin
            size_reg  <= size_in;
            count_reg <= '0;
        end else if (xfer) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // One register per slot: cleared on start, written when its index comes up.
    genvar gi;
    generate
        for (gi = 0; gi < N_MAX; gi++) begin : g_slot
            logic [ELEM_W-1:0] slot_reg;

            // Slot gi captures data_in verbatim on the transfer that targets it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (load_start) begin
                    slot_reg <= '0;
                end else if (xfer && (count_reg == CNT_W'(gi))) begin
                    slot_reg <= data_in;
                end
            end

            assign matrix_A[gi*ELEM_W +: ELEM_W] = slot_reg;
        end
    endgenerate

    assign matrix_size = size_reg;
    assign elem_count  = count_reg;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: one task per scenario, inline checks.
module tb_matrix_loader;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   size_in;
    logic [7:0]   data_in;
    logic         data_valid;
    logic         data_ready;
    logic [199:0] matrix_A;
    logic [1:0]   matrix_size;
    logic         matrix_valid;
    logic         ack;
    logic         busy;
    logic [4:0]   elem_count;

    int n_cmp;
    int n_bad;

    matrix_loader #(.ELEM_W(8), .N_MAX(25)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .size_in      (size_in),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .matrix_A     (matrix_A),
        .matrix_size  (matrix_size),
        .matrix_valid (matrix_valid),
        .ack          (ack),
        .busy         (busy),
        .elem_count   (elem_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        data_valid = 1'b1;
        data_in    = v;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic begin_load(input logic [1:0] sz);
        start   = 1'b1;
        size_in = sz;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (data_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_ready: got %b want 0", data_ready); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (matrix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", matrix_valid); end
        n_cmp++; if (elem_count !== 5'd0)   begin n_bad++; $display("FAIL reset_count: got %0d want 0", elem_count); end
        n_cmp++; if (matrix_size !== 2'b00) begin n_bad++; $display("FAIL reset_size: got %b want 00", matrix_size); end
        n_cmp++; if (matrix_A !== 200'd0)   begin n_bad++; $display("FAIL reset_matrix: got %h want 0", matrix_A); end
        $display("txn reset: done");
    endtask

    task automatic test_2x2();
        do_reset();
        begin_load(2'b00);
        n_cmp++; if (data_ready !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL 2x2_start_latency: got ready=%b busy=%b want 1 1", data_ready, busy); end
        send(8'h01);
        send(8'hFF);
        send(8'h80);
        n_cmp++; if (matrix_valid !== 1'b0) begin n_bad++; $display("FAIL 2x2_early_valid: got %b want 0", matrix_valid); end
        n_cmp++; if (matrix_A[23:0] !== 24'h80FF01) begin n_bad++; $display("FAIL 2x2_partial: got %h want 80ff01", matrix_A[23:0]); end
        send(8'h7F);
        n_cmp++; if (matrix_valid !== 1'b1 || data_ready !== 1'b0) begin n_bad++; $display("FAIL 2x2_done: got valid=%b ready=%b want 1 0", matrix_valid, data_ready); end
        n_cmp++; if (matrix_A[31:0] !== 32'h7F80FF01) begin n_bad++; $display("FAIL 2x2_low: got %h want 7f80ff01", matrix_A[31:0]); end
        n_cmp++; if (matrix_A[199:32] !== 168'd0) begin n_bad++; $display("FAIL 2x2_high: got %h want 0", matrix_A[199:32]); end
        n_cmp++; if (elem_count !== 5'd4) begin n_bad++; $display("FAIL 2x2_count: got %0d want 4", elem_count); end
        n_cmp++; if (matrix_size !== 2'b00) begin n_bad++; $display("FAIL 2x2_size: got %b want 00", matrix_size); end
        do_ack();
        n_cmp++; if (matrix_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL 2x2_ack: got valid=%b busy=%b want 0 0", matrix_valid, busy); end
        $display("txn 2x2: A[31:0]=%h count=%0d", matrix_A[31:0], elem_count);
    endtask

    task automatic test_5x5_gaps();
        logic [199:0] exp;
        int bad_ready;
        int bad_valid;
        exp = '0;
        bad_ready = 0;
        bad_valid = 0;
        begin_load(2'b11);
        for (int i = 0; i < 25; i++) begin
            if (i % 2 == 0 && i != 0) begin
                data_valid = 1'b0;
                data_in    = 8'hEE;
                tick();
                if (data_ready !== 1'b1) bad_ready++;
                if (matrix_valid !== 1'b0) bad_valid++;
            end
            send(8'(i));
            exp[i*8 +: 8] = 8'(i);
            if (i < 24) begin
                if (data_ready !== 1'b1) bad_ready++;
                if (matrix_valid !== 1'b0) bad_valid++;
            end
        end
        n_cmp++; if (bad_ready != 0) begin n_bad++; $display("FAIL 5x5_ready_in_load: got %0d low cycles want 0", bad_ready); end
        n_cmp++; if (bad_valid != 0) begin n_bad++; $display("FAIL 5x5_early_valid: got %0d valid cycles want 0", bad_valid); end
        n_cmp++; if (matrix_valid !== 1'b1) begin n_bad++; $display("FAIL 5x5_valid: got %b want 1", matrix_valid); end
        n_cmp++; if (matrix_A !== exp) begin n_bad++; $display("FAIL 5x5_matrix: got %h want %h", matrix_A, exp); end
        n_cmp++; if (elem_count !== 5'd25) begin n_bad++; $display("FAIL 5x5_count: got %0d want 25", elem_count); end
        do_ack();
        $display("txn 5x5_gaps: count=%0d size=%b", elem_count, matrix_size);
    endtask

    task automatic test_clear();
        logic [199:0] exp;
        exp = '0;
        begin_load(2'b11);
        for (int i = 0; i < 25; i++) send(8'hAA);
        do_ack();
        n_cmp++; if (matrix_A[199:192] !== 8'hAA) begin n_bad++; $display("FAIL clear_held_idle: got %h want aa", matrix_A[199:192]); end
        begin_load(2'b01);
        n_cmp++; if (matrix_A !== 200'd0) begin n_bad++; $display("FAIL clear_on_start: got %h want 0", matrix_A); end
        for (int i = 0; i < 9; i++) begin
            send(8'h11);
            exp[i*8 +: 8] = 8'h11;
        end
        n_cmp++; if (matrix_A !== exp) begin n_bad++; $display("FAIL clear_3x3: got %h want %h", matrix_A, exp); end
        n_cmp++; if (matrix_size !== 2'b01 || matrix_valid !== 1'b1) begin n_bad++; $display("FAIL clear_3x3_status: got size=%b valid=%b want 01 1", matrix_size, matrix_valid); end
        do_ack();
        $display("txn clear: A=%h", matrix_A);
    endtask

    task automatic test_ignored_start();
        logic [199:0] exp;
        exp = '0;
        begin_load(2'b10);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start   = 1'b1;
                size_in = 2'b00;
            end
            send(8'h30 + 8'(i));
            start = 1'b0;
            exp[i*8 +: 8] = 8'h30 + 8'(i);
            if (i == 5) begin
                n_cmp++; if (matrix_size !== 2'b10 || elem_count !== 5'd6) begin n_bad++; $display("FAIL ign_start_load: got size=%b count=%0d want 10 6", matrix_size, elem_count); end
            end
        end
        n_cmp++; if (matrix_valid !== 1'b1 || elem_count !== 5'd16) begin n_bad++; $display("FAIL ign_done: got valid=%b count=%0d want 1 16", matrix_valid, elem_count); end
        start   = 1'b1;
        size_in = 2'b00;
        tick();
        n_cmp++; if (matrix_valid !== 1'b1 || matrix_size !== 2'b10 || elem_count !== 5'd16) begin n_bad++; $display("FAIL ign_start_done: got valid=%b size=%b count=%0d want 1 10 16", matrix_valid, matrix_size, elem_count); end
        n_cmp++; if (matrix_A !== exp) begin n_bad++; $display("FAIL ign_matrix: got %h want %h", matrix_A, exp); end
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || data_ready !== 1'b0) begin n_bad++; $display("FAIL ign_start_with_ack: got busy=%b ready=%b want 0 0", busy, data_ready); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_stays_idle: got busy=%b want 0", busy); end
        $display("txn ignored_start: size=%b count=%0d", matrix_size, elem_count);
    endtask

    task automatic test_hold();
        logic [199:0] snap;
        int bad_hold;
        bad_hold = 0;
        begin_load(2'b00);
        send(8'h10);
        send(8'h11);
        send(8'h12);
        send(8'h13);
        snap = 200'h13121110;
        n_cmp++; if (matrix_A !== snap) begin n_bad++; $display("FAIL hold_loaded: got %h want %h", matrix_A, snap); end
        for (int c = 0; c < 10; c++) begin
            data_valid = c[0];
            data_in    = 8'hC0 + 8'(c);
            tick();
            if (matrix_A !== snap || data_ready !== 1'b0 || matrix_valid !== 1'b1 || elem_count !== 5'd4) bad_hold++;
        end
        data_valid = 1'b0;
        n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad_hold); end
        do_ack();
        n_cmp++; if (matrix_valid !== 1'b0) begin n_bad++; $display("FAIL hold_ack: got %b want 0", matrix_valid); end
        n_cmp++; if (matrix_A !== snap) begin n_bad++; $display("FAIL hold_after_ack: got %h want %h", matrix_A, snap); end
        $display("txn hold: A[31:0]=%h", matrix_A[31:0]);
    endtask

    task automatic test_rst_mid();
        logic [199:0] exp;
        exp = '0;
        begin_load(2'b01);
        for (int i = 0; i < 6; i++) send(8'h55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (matrix_A !== 200'd0 || elem_count !== 5'd0 || matrix_size !== 2'b00) begin n_bad++; $display("FAIL rstmid_regs: got A=%h count=%0d size=%b want 0 0 00", matrix_A, elem_count, matrix_size); end
        n_cmp++; if (busy !== 1'b0 || data_ready !== 1'b0 || matrix_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got busy=%b ready=%b valid=%b want 0 0 0", busy, data_ready, matrix_valid); end
        begin_load(2'b01);
        for (int i = 0; i < 9; i++) begin
            send(8'h80 + 8'(i));
            exp[i*8 +: 8] = 8'h80 + 8'(i);
        end
        n_cmp++; if (matrix_A !== exp) begin n_bad++; $display("FAIL rstmid_reload: got %h want %h", matrix_A, exp); end
        n_cmp++; if (matrix_valid !== 1'b1 || elem_count !== 5'd9 || matrix_size !== 2'b01) begin n_bad++; $display("FAIL rstmid_status: got valid=%b count=%0d size=%b want 1 9 01", matrix_valid, elem_count, matrix_size); end
        do_ack();
        $display("txn rst_mid: reload count=%0d", elem_count);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        size_in    = 2'b00;
        data_in    = 8'h00;
        data_valid = 1'b0;
        ack        = 1'b0;
        test_reset();
        test_2x2();
        test_5x5_gaps();
        test_clear();
        test_ignored_start();
        test_hold();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream packing stage of the arithmetic coprocessor. Accepts signed 8-bit matrix elements one per handshake from the host/memory interface and assembles them row-major into the 200-bit flat matrix bus consumed by the operation units (opposite, transpose, add, etc.). Unused element slots are zeroed, the size code is registered alongside, and a `matrix_valid`/`ack` handshake holds the result stable until the consumer takes it.

## Interface
- `ELEM_W`, 8: element width in bits, two's complement.
- `N_MAX`, 25: element slots on the output bus, a 5x5 matrix.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin loading; sampled only in IDLE.
- `size_in` input 2: size code latched with `start`: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- `data_in` input 8: element value.
- `data_valid` input 1: `data_in` is valid this cycle.
- `data_ready` output 1: loader accepts an element this cycle.
- `matrix_A` output 200: element i (i = row*n + col) at bits [i*8 +: 8].
- `matrix_size` output 2: registered size code for `matrix_A`.
- `matrix_valid` output 1: `matrix_A`/`matrix_size` are complete and stable.
- `ack` input 1: consumer has taken the matrix.
- `busy` output 1: high in LOAD and DONE.
- `elem_count` output 5: elements accepted in the current load, 0..25.

## Operation
- FSM states: IDLE, LOAD, DONE.
- Target count N is 4/9/16/25 for size codes 00/01/10/11.
- **IDLE**
  - On `start`=1: latch `size_in` into `matrix_size`, clear all of `matrix_A` to 0, clear `elem_count`, go to LOAD.
  - Otherwise hold; `matrix_A` keeps its last loaded contents.
- **LOAD**
  - `data_ready`=1.
  - A transfer occurs when `data_valid` && `data_ready`: write `data_in` into slot `elem_count`, then increment `elem_count`.
  - When the transfer is element N-1, go to DONE.
  - Cycles with `data_valid`=0 are idle gaps; no state change.
- **DONE**
  - `data_ready`=0, `matrix_valid`=1.
  - On `ack`=1, go to IDLE.
  - `matrix_A`, `matrix_size` and `elem_count` are held.
- `start` in LOAD or DONE is ignored, with no effect on any register.
- `ack` outside DONE is ignored.
- `start` and `ack` in the same DONE cycle: `ack` is honoured; `start` is ignored and must be reissued in IDLE.
- Slots N..24 stay 0 after every load.
- No arithmetic or sign change is applied; bytes are stored verbatim.
- `data_in` is ignored whenever `data_ready`=0.

## Timing
- Reset values: state IDLE, `matrix_A`=0, `matrix_size`=00, `matrix_valid`=0, `data_ready`=0, `busy`=0, `elem_count`=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Start latency: `start` at edge T, then `data_ready`=1 and `busy`=1 from T+1.
- Throughput: one element per cycle. Minimum load of N elements accepted on cycles T+1..T+N.
- Completion: last transfer at edge E, then `matrix_valid`=1 and `data_ready`=0 from E+1. Written slot values are visible on `matrix_A` from the cycle after each transfer.
- `ack` at edge A in DONE: `matrix_valid`=0 and `busy`=0 from A+1; a new `start` is accepted at A+1 at the earliest.
- `rst` mid-load or in DONE: all registers return to reset values at the next edge. The partial matrix is discarded.

## Test plan
- **2x2 load:** reset, `start` with `size_in`=00, then stream 0x01, 0xFF, 0x80, 0x7F back-to-back. Required: `matrix_valid` 5 cycles after `start`, `matrix_A[31:0]`=0x7F80FF01, bits [199:32]=0, `elem_count`=4, `matrix_size`=00.
- **5x5 with gaps:** size 11, elements 0..24 with `data_valid` deasserted every third cycle. Required: byte i = i, `matrix_valid` only after the 25th transfer, `data_ready` high throughout LOAD.
- **Clearing after a smaller load:** load 5x5 of all 0xAA, `ack`, then load 3x3 of 0x11. Required: slots 0..8 = 0x11, slots 9..24 = 0x00.
- **Ignored start:** `start` with size 00 during a 4x4 LOAD and again during DONE. Required: `matrix_size` stays 10, count is unaffected, 16 elements accepted.
- **Hold and ack:** keep `ack` low for 10 cycles in DONE while toggling `data_valid`/`data_in`. Required: `matrix_A` unchanged and `data_ready`=0 throughout; after `ack`, `matrix_valid`=0 the next cycle.
- **Reset mid-load:** assert `rst` after 6 of 9 elements. Required: all outputs at reset values the next cycle; a subsequent full 3x3 load completes correctly.
